// File: rtl/norm_seq32.sv
// rtl/norm_seq32.sv - 32-bit normalizer: leading-zero count and left shift using one shared 16-bit leading-one detector
// Optional macro NORM_BACK2BACK_EN lets HOLD accept the next operand while the result is taken.
module norm_seq32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [5:0]  out_lz,
  output logic        out_zero,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, DET_HI, DET_LO, SHIFT, HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] data_q, data_d;
  logic [5:0]  lz_q, lz_d;
  logic        zero_q, zero_d;
  logic [31:0] out_data_q, out_data_d;
  logic [5:0]  out_lz_q, out_lz_d;
  logic        out_zero_q, out_zero_d;
  logic        out_valid_q, out_valid_d;
  logic        busy_q, busy_d;
  logic        rdy_en_q, rdy_en_d;

  logic [15:0] det_in;
  logic [3:0]  det_pos;
  logic        det_nz;

  // Detector input is parked at zero outside the two detect states.
  always_comb begin
    det_in = 16'h0000;
    if (state_q == DET_HI) det_in = data_q[31:16];
    else if (state_q == DET_LO) det_in = data_q[15:0];
  end

  always_comb begin
    det_pos = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (det_in[i]) det_pos = 4'(i);
    end
    det_nz = |det_in;
  end

  // rdy_en_q keeps in_ready low until the first clock after reset release.
`ifdef NORM_BACK2BACK_EN
  assign in_ready = rdy_en_q & ((state_q == IDLE) | ((state_q == HOLD) & out_ready));
`else
  assign in_ready = rdy_en_q & (state_q == IDLE);
`endif

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    lz_d       = lz_q;
    zero_d     = zero_q;
    out_data_d = out_data_q;
    out_lz_d   = out_lz_q;
    out_zero_d = out_zero_q;
    rdy_en_d   = 1'b1;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          data_d  = in_data;
          state_d = DET_HI;
        end
      end
      DET_HI: begin
        if (det_nz) begin
          lz_d    = 6'd15 - {2'b00, det_pos};
          zero_d  = 1'b0;
          state_d = SHIFT;
        end else begin
          state_d = DET_LO;
        end
      end
      DET_LO: begin
        if (det_nz) begin
          lz_d   = 6'd31 - {2'b00, det_pos};
          zero_d = 1'b0;
        end else begin
          lz_d   = 6'd32;
          zero_d = 1'b1;
        end
        state_d = SHIFT;
      end
      SHIFT: begin
        out_data_d = lz_q[5] ? 32'h0 : (data_q << lz_q[4:0]);
        out_lz_d   = lz_q;
        out_zero_d = zero_q;
        state_d    = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
`ifdef NORM_BACK2BACK_EN
          if (in_valid && in_ready) begin
            data_d  = in_data;
            state_d = DET_HI;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    out_valid_d = (state_d == HOLD);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      data_q      <= 32'h0;
      lz_q        <= 6'd0;
      zero_q      <= 1'b0;
      out_data_q  <= 32'h0;
      out_lz_q    <= 6'd0;
      out_zero_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      rdy_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      lz_q        <= lz_d;
      zero_q      <= zero_d;
      out_data_q  <= out_data_d;
      out_lz_q    <= out_lz_d;
      out_zero_q  <= out_zero_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      rdy_en_q    <= rdy_en_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_lz    = out_lz_q;
  assign out_zero  = out_zero_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule
